// File: rtl/bf16_matmul_seq_if.sv
// Bundles the start/busy/done handshake, the operands and the result of the
// sequential bfloat16 matrix multiplier.
//
// Handshake: the master pulses start for one cycle. The pulse is taken only
// while the engine is idle and busy is low. busy rises in the next cycle and
// stays high through the compute phase. done pulses for exactly one cycle,
// and busy falls in that same cycle. C is valid from that cycle onward and
// holds until the next accepted start or a reset. A, B and acc_en are
// sampled only on the accepting edge.
interface bf16_matmul_seq_if #(
  parameter int N    = 16,
  parameter int SIZE = 4
);
  logic         start;
  logic         acc_en;
  logic [N-1:0] A [SIZE-1:0][SIZE-1:0];
  logic [N-1:0] B [SIZE-1:0][SIZE-1:0];
  logic         busy;
  logic         done;
  logic [N-1:0] C [SIZE-1:0][SIZE-1:0];

  modport master (output start, acc_en, A, B, input busy, done, C);
  modport slave  (input start, acc_en, A, B, output busy, done, C);
endinterface

// File: rtl/bf16_matmul_seq.sv
// Sequential bfloat16 matrix multiplier: C = A x B, or C = C + A x B.
// SIZE*SIZE output-stationary MAC lanes consume one k index per clock.
// Arithmetic truncates, flushes denormals and saturates to +/-7F7F.
module bf16_matmul_seq #(
  parameter int N    = 16,
  parameter int SIZE = 4,
  parameter int KW   = $clog2(SIZE)
) (
  input  logic              clk,
  input  logic              rst,
  bf16_matmul_seq_if.slave  bus,
  output logic [1:0]        o_dbg_state
);

  if (N != 16) begin : g_bad_n
    $error("bf16_matmul_seq: only N=16 (bfloat16) is supported");
  end
  if (SIZE < 2 || SIZE > 8) begin : g_bad_size
    $error("bf16_matmul_seq: SIZE must be in 2..8");
  end

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_LOAD = 2'd1, S_COMP = 2'd2, S_DONE = 2'd3} state_t;

  state_t        r_state;
  logic [KW-1:0] r_k;
  logic          r_busy;
  logic          r_done;
  logic [N-1:0]  r_a   [SIZE-1:0][SIZE-1:0];
  logic [N-1:0]  r_b   [SIZE-1:0][SIZE-1:0];
  logic [N-1:0]  r_acc [SIZE-1:0][SIZE-1:0];
  logic [N-1:0]  r_c   [SIZE-1:0][SIZE-1:0];
  logic [N-1:0]  w_sum [SIZE-1:0][SIZE-1:0];

  // The 1.7 significand product lies in [1,4). Normalise with at most one shift and truncate.
  function automatic logic [15:0] bf16_mul(input logic [15:0] a, input logic [15:0] b);
    logic              s;
    logic [15:0]       p;
    logic signed [9:0] e;
    logic [6:0]        m;
    logic [15:0]       r;
    s = a[15] ^ b[15];
    p = {8'd0, 1'b1, a[6:0]} * {8'd0, 1'b1, b[6:0]};
    e = $signed({2'b00, a[14:7]}) + $signed({2'b00, b[14:7]}) - 10'sd127;
    if (p[15]) begin
      m = p[14:8];
      e = e + 10'sd1;
    end else begin
      m = p[13:7];
    end
    if (a[14:7] == 8'd0 || b[14:7] == 8'd0) r = 16'h0000;
    else if (e <= 10'sd0)                   r = 16'h0000;
    else if (e >= 10'sd255)                 r = {s, 15'h7F7F};
    else                                    r = {s, e[7:0], m};
    return r;
  endfunction

  // The smaller magnitude is aligned with 3 guard bits. The result is renormalised
  // around its leading one and the guard bits are truncated away.
  function automatic logic [15:0] bf16_add(input logic [15:0] a, input logic [15:0] b);
    logic [15:0]       big;
    logic [15:0]       sml;
    logic [7:0]        sh;
    logic [10:0]       mb;
    logic [10:0]       ms;
    logic [11:0]       v;
    logic [11:0]       vn;
    logic [3:0]        p;
    logic signed [9:0] e;
    logic [15:0]       r;
    big = a;
    sml = b;
    if (a[14:0] < b[14:0]) begin
      big = b;
      sml = a;
    end
    sh = big[14:7] - sml[14:7];
    mb = {1'b1, big[6:0], 3'b000};
    ms = {1'b1, sml[6:0], 3'b000} >> sh;
    v  = (big[15] == sml[15]) ? ({1'b0, mb} + {1'b0, ms}) : ({1'b0, mb} - {1'b0, ms});
    p  = 4'd0;
    for (int i = 0; i < 12; i++) begin
      if (v[i]) p = 4'(i);
    end
    vn = v << (4'd11 - p);
    e  = $signed({2'b00, big[14:7]}) + $signed({6'd0, p}) - 10'sd10;
    if (a[14:7] == 8'd0)       r = (b[14:7] == 8'd0) ? 16'h0000 : b;
    else if (b[14:7] == 8'd0)  r = a;
    else if (v == 12'd0)       r = 16'h0000;
    else if (e <= 10'sd0)      r = 16'h0000;
    else if (e >= 10'sd255)    r = {big[15], 15'h7F7F};
    else                       r = {big[15], e[7:0], vn[10:4]};
    return r;
  endfunction

  // One combinational MAC per output element for the current k.
  for (genvar gi = 0; gi < SIZE; gi++) begin : g_row
    for (genvar gj = 0; gj < SIZE; gj++) begin : g_col
      assign w_sum[gi][gj] = bf16_add(r_acc[gi][gj], bf16_mul(r_a[gi][r_k], r_b[r_k][gj]));
    end
  end

  // Control FSM. It also owns the operand, accumulator and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_k     <= '0;
      for (int i = 0; i < SIZE; i++) begin
        for (int j = 0; j < SIZE; j++) begin
          r_a[i][j]   <= '0;
          r_b[i][j]   <= '0;
          r_acc[i][j] <= '0;
          r_c[i][j]   <= '0;
        end
      end
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_a     <= bus.A;
            r_b     <= bus.B;
            r_k     <= '0;
            r_busy  <= 1'b1;
            r_state <= S_LOAD;
            for (int i = 0; i < SIZE; i++) begin
              for (int j = 0; j < SIZE; j++) begin
                r_acc[i][j] <= bus.acc_en ? r_c[i][j] : '0;
              end
            end
          end
        end
        S_LOAD: r_state <= S_COMP;
        S_COMP: begin
          r_acc <= w_sum;
          r_k   <= r_k + 1'b1;
          if (r_k == KW'(SIZE - 1)) begin
            r_c     <= w_sum;
            r_k     <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.C       = r_c;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_bf16_matmul_seq.sv
// Directed bench for bf16_matmul_seq: a SIZE=4 instance and a SIZE=2 instance.
module tb_bf16_matmul_seq;

  logic       clk;
  logic       rst;
  logic [1:0] dbg4;
  logic [1:0] dbg2;
  int         total = 0;
  int         bad   = 0;
  int         lat;
  int         nbusy;
  int         ndone;

  bf16_matmul_seq_if #(.N(16), .SIZE(4)) bus4 ();
  bf16_matmul_seq_if #(.N(16), .SIZE(2)) bus2 ();

  bf16_matmul_seq #(.N(16), .SIZE(4)) u_dut4 (.clk(clk), .rst(rst), .bus(bus4), .o_dbg_state(dbg4));
  bf16_matmul_seq #(.N(16), .SIZE(2)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2), .o_dbg_state(dbg2));

  // Clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Checks every row of the SIZE=4 result against one expected row.
  task automatic chk_c4(input string tag, input logic [15:0] e0, input logic [15:0] e1,
                        input logic [15:0] e2, input logic [15:0] e3);
    logic [15:0] e [4];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        chk($sformatf("%s C[%0d][%0d]", tag, i, j), 32'(bus4.C[i][j]), 32'(e[j]));
  endtask

  task automatic clear4();
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        bus4.A[i][j] = 16'h0000;
        bus4.B[i][j] = 16'h0000;
      end
  endtask

  // Every row of A and of B is {1,2,3,4}.
  task automatic load_basic4();
    logic [15:0] v [4];
    v[0] = 16'h3F80; v[1] = 16'h4000; v[2] = 16'h4040; v[3] = 16'h4080;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        bus4.A[i][j] = v[j];
        bus4.B[i][j] = v[j];
      end
  endtask

  // Starts in the cycle after the current one and returns when done is seen.
  // lat is the number of cycles after the start cycle, or -1 on timeout.
  task automatic run4(input logic acc, output int lat_o, output int nbusy_o);
    lat_o = -1;
    nbusy_o = 0;
    @(posedge clk);
    @(negedge clk);
    bus4.start  = 1'b1;
    bus4.acc_en = acc;
    @(posedge clk); #1;
    bus4.start = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (bus4.busy) nbusy_o++;
      if (bus4.done) begin
        lat_o = c;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst = 1'b1;
    bus4.start = 1'b0; bus4.acc_en = 1'b0;
    bus2.start = 1'b0; bus2.acc_en = 1'b0;
    clear4();
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        bus2.A[i][j] = 16'h0000;
        bus2.B[i][j] = 16'h0000;
      end

    // Reset state.
    @(negedge clk);
    rst = 1'b0;
    chk("rst busy", 32'(bus4.busy), 32'd0);
    chk("rst done", 32'(bus4.done), 32'd0);
    chk("rst state", 32'(dbg4), 32'd0);
    chk_c4("rst", 16'h0000, 16'h0000, 16'h0000, 16'h0000);

    // Basic product: 10,20,30,40 in every row.
    load_basic4();
    run4(1'b0, lat, nbusy);
    chk("basic latency", 32'(lat), 32'd6);
    chk("basic busy cycles", 32'(nbusy), 32'd5);
    chk("basic busy low at done", 32'(bus4.busy), 32'd0);
    chk_c4("basic", 16'h4120, 16'h41A0, 16'h41F0, 16'h4220);

    // Accumulate, started in the cycle right after done: 20,40,60,80.
    run4(1'b1, lat, nbusy);
    chk("acc latency", 32'(lat), 32'd6);
    chk_c4("acc", 16'h41A0, 16'h4220, 16'h4270, 16'h42A0);

    // Saturation: 2^127 * 2 overflows.
    clear4();
    bus4.A[0][0] = 16'h7F00;
    bus4.B[0][0] = 16'h4000;
    run4(1'b0, lat, nbusy);
    chk("sat latency", 32'(lat), 32'd6);
    chk("sat C[0][0]", 32'(bus4.C[0][0]), 32'h7F7F);
    chk("sat C[1][1]", 32'(bus4.C[1][1]), 32'h0000);

    // Cancellation: 1*1 + (-1)*1 = +0.
    clear4();
    bus4.A[0][0] = 16'h3F80; bus4.A[0][1] = 16'hBF80;
    bus4.B[0][0] = 16'h3F80; bus4.B[1][0] = 16'h3F80;
    run4(1'b0, lat, nbusy);
    chk("cancel C[0][0]", 32'(bus4.C[0][0]), 32'h0000);

    // Protocol: extra start pulses in COMP and DONE, with different operands, are ignored.
    load_basic4();
    @(posedge clk);
    @(negedge clk);
    bus4.start = 1'b1; bus4.acc_en = 1'b0;
    @(posedge clk); #1;
    bus4.start = 1'b0;
    ndone = 0;
    lat = -1;
    for (int c = 1; c <= 16; c++) begin
      if (bus4.done) begin
        ndone++;
        if (lat < 0) lat = c;
      end
      if (c == 3 || c == 6) begin
        bus4.start = 1'b1; bus4.acc_en = 1'b1;
        for (int i = 0; i < 4; i++)
          for (int j = 0; j < 4; j++) bus4.A[i][j] = 16'h4080;
      end else begin
        bus4.start = 1'b0;
        load_basic4();
      end
      @(posedge clk); #1;
    end
    chk("proto latency", 32'(lat), 32'd6);
    chk("proto done count", 32'(ndone), 32'd1);
    chk_c4("proto", 16'h4120, 16'h41A0, 16'h41F0, 16'h4220);

    // Reset mid-operation aborts and clears C.
    run4(1'b1, lat, nbusy);
    chk_c4("pre-abort", 16'h41A0, 16'h4220, 16'h4270, 16'h42A0);
    @(posedge clk);
    @(negedge clk);
    bus4.start = 1'b1; bus4.acc_en = 1'b0;
    @(posedge clk); #1;
    bus4.start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort busy", 32'(bus4.busy), 32'd0);
    chk("abort state", 32'(dbg4), 32'd0);
    chk_c4("abort", 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    ndone = 0;
    for (int c = 0; c < 10; c++) begin
      if (bus4.done) ndone++;
      @(posedge clk); #1;
    end
    chk("abort no done", 32'(ndone), 32'd0);
    run4(1'b0, lat, nbusy);
    chk("post-abort latency", 32'(lat), 32'd6);
    chk_c4("post-abort", 16'h4120, 16'h41A0, 16'h41F0, 16'h4220);

    // SIZE=2: the identity times itself gives the identity, 4 cycles after start.
    bus2.A[0][0] = 16'h3F80; bus2.A[1][1] = 16'h3F80;
    bus2.B[0][0] = 16'h3F80; bus2.B[1][1] = 16'h3F80;
    @(negedge clk);
    bus2.start = 1'b1; bus2.acc_en = 1'b0;
    @(posedge clk); #1;
    bus2.start = 1'b0;
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      if (bus2.done) begin
        lat = c;
        break;
      end
      @(posedge clk); #1;
    end
    chk("s2 latency", 32'(lat), 32'd4);
    chk("s2 C[0][0]", 32'(bus2.C[0][0]), 32'h3F80);
    chk("s2 C[0][1]", 32'(bus2.C[0][1]), 32'h0000);
    chk("s2 C[1][0]", 32'(bus2.C[1][0]), 32'h0000);
    chk("s2 C[1][1]", 32'(bus2.C[1][1]), 32'h3F80);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bf16_matmul_seq.md
Name: bf16_matmul_seq

Overview:
- Parametrised sequential successor to the combinational bfloat16 matrix multiplier.
- Computes C = A x B, or C = C + A x B in accumulate mode, for SIZE x SIZE bfloat16 matrices.
- Uses SIZE*SIZE output-stationary MAC lanes and steps one k index per clock.
- A single start/busy/done handshake replaces the per-element OP_START/OP_FINISH arrays.

Parameters:
- N, 16, element width; only 16 (bfloat16) is supported, any other value is an elaboration error.
- SIZE, 4, matrix dimension; legal range 2..8.
- KW, $clog2(SIZE), width of the k counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  single-cycle request; accepted only in IDLE.
- acc_en  input  1  sampled with start; 1 = accumulate into the current C, 0 = overwrite.
- A  input  N, unpacked [SIZE-1:0][SIZE-1:0]  left operand, indexed A[row][col].
- B  input  N, unpacked [SIZE-1:0][SIZE-1:0]  right operand, indexed B[row][col].
- busy  output  1  high while computing.
- done  output  1  one-cycle pulse when C is valid.
- C  output  N, unpacked [SIZE-1:0][SIZE-1:0]  result registers; hold their value until the next accepted start or reset.

Behaviour:
- Reset (one cycle, synchronous, active-high):
  - state = IDLE.
  - busy = 0, done = 0.
  - all C = 16'h0000, k = 0, operand registers = 0.
- FSM states and transitions:
  - IDLE -> LOAD on start.
  - LOAD -> COMP.
  - COMP stays while k < SIZE-1; -> DONE when k = SIZE-1.
  - DONE -> IDLE.
- Start accepted (edge 0):
  - A and B are captured into internal registers; inputs may change afterwards.
  - If acc_en = 0, accumulators are loaded with +0; if acc_en = 1, accumulators are loaded from C.
- LOAD: busy = 1.
- COMP, each cycle: every lane updates acc[i][j] = acc[i][j] + A[i][k]*B[k][j], then k increments.
- Timing:
  - There are exactly SIZE COMP cycles.
  - C is updated from the accumulators on the DONE edge.
  - done = 1 for exactly the one cycle spent in DONE.
  - busy drops in that same cycle.
- Latency: start edge to done high is SIZE+2 cycles (6 for SIZE=4).
- A start in any state other than IDLE is ignored with no side effects. A start during DONE is also ignored; a new start is accepted in the cycle after done.
- Reset mid-operation aborts the computation: C is cleared and no done is issued.
- bf16 multiply:
  - sign = sa ^ sb.
  - exponent = ea + eb - 127.
  - mantissa = 8x8-bit product of the 1.7 significands, normalised with a 1-bit shift.
  - Truncate to 7 fraction bits (round toward zero).
- bf16 add:
  - Align the smaller exponent by right shift, keeping 3 guard bits that are then discarded (truncation).
  - Add or subtract the magnitudes; the sign follows the larger magnitude.
  - Renormalise with a leading-zero count.
- Special values:
  - Any operand with exponent 0 is treated as zero (denormals flushed).
  - A result with exponent <= 0 flushes to +0.
  - A result with exponent >= 255 saturates to sign|16'h7F7F.
  - Exact cancellation gives +0.
  - Inf/NaN inputs are unsupported: exponent 255 is treated as an ordinary finite exponent, so the result is undefined but must not hang the FSM.
- Each lane is purely combinational within one cycle. There is no internal pipelining, so lane critical path = multiplier + adder.

Test Plan:
- Basic product: rst for 1 cycle, then start with acc_en=0, every A row = {3F80,4000,4040,4080} and every B row = {3F80,4000,4040,4080} (1,2,3,4). Required: done exactly 6 cycles after start; C[i][0..3] = 4120,41A0,41F0,4220 (10,20,30,40) for all i; busy high for 5 cycles.
- Accumulate: repeat the previous run with acc_en=1. Required: C[i][0..3] = 41A0,4220,4270,42A0 (20,40,60,80).
- Saturation and cancellation: A[0][0]=7F00, B[0][0]=4000, all other elements 0. Required: C[0][0] = 7F7F.
  - Second run: A row0 = {3F80,BF80,0,0}, B column0 = {3F80,3F80,0,0}. Required: C[0][0] = 0000.
- Protocol: start pulsed again in COMP and in DONE. Required: ignored, a single done, C unchanged by the extra pulses.
  - Then start one cycle after done. Required: accepted.
- Reset mid-op: rst asserted 2 cycles after start. Required: busy=0, done never pulses, all C = 0000.
  - Then a normal start. Required: correct result (same values as the basic-product run).
- SIZE=2 build: A = B = identity (3F80 on the diagonal). Required: C = identity, done 4 cycles after start.
